mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the instruction-fetch requester
//            (IF) and the MEM-stage load/store requester.
//
//            The MEM requester normally has priority. Once it has taken two
//            grants in a row while a fetch was waiting, the next grant goes
//            to IF. Each transaction runs IDLE -> busy -> RESP -> IDLE, so
//            only one transaction is outstanding at a time.
//
//            A bus wait counter aborts a transaction after TIMEOUT cycles
//            without bus_ready. The aborted transaction returns zero data
//            and pulses bus_err. A fetch can be discarded while it is in
//            flight with if_kill; the bus cycle still completes, but its
//            data and ready pulse are dropped.
//
// Ports    : clk, rst                       - clock, synchronous active-high reset
//            if_req/if_addr/if_kill         - fetch request, address, discard
//            if_ready/if_rdata              - fetch completion pulse and data
//            mem_req/mem_we/mem_addr/
//            mem_wdata/mem_wstrb            - MEM-stage load/store request
//            mem_ready/mem_rdata            - MEM completion pulse and load data
//            bus_valid/bus_we/bus_addr/
//            bus_wdata/bus_wstrb            - shared memory port request
//            bus_ready/bus_rdata            - shared memory port response
//            stall_if/stall_mem             - pipeline stall requests
//            bus_err                        - timeout error pulse (during RESP)
// Parameter: TIMEOUT (1..255)               - bus wait cycles before an abort
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_IF_BUSY  = 2'd1;
    localparam logic [1:0] c_MEM_BUSY = 2'd2;
    localparam logic [1:0] c_RESP     = 2'd3;

    // The counter value seen in the last busy cycle before an abort. With
    // the counter starting at 0, this gives exactly TIMEOUT busy cycles.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_grant_mem;   // requester owning the current transaction
    logic [1:0]  r_fair_cnt;    // consecutive MEM grants made while IF waited
    logic [7:0]  r_wait_cnt;
    logic        r_kill;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    logic        w_resp;
    logic        w_if_wins;
    logic        w_timeout;
    logic        w_kill_next;
    logic [31:0] w_done_data;

    assign w_resp    = (r_state == c_RESP);
    assign w_if_wins = if_req & (~mem_req | (r_fair_cnt == 2'd2));

    // bus_ready beats the timeout when both land in the same cycle.
    assign w_timeout = ~bus_ready & (r_wait_cnt == c_WAIT_LAST);

    // A kill arriving in the completing cycle must still discard the data.
    assign w_kill_next = r_kill | ((r_state == c_IF_BUSY) & if_kill);

    assign w_done_data = bus_ready ? bus_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_grant_mem <= 1'b0;
            r_fair_cnt  <= 2'd0;
            r_wait_cnt  <= 8'd0;
            r_kill      <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'b0000;
            r_if_rdata  <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (if_req | mem_req) begin
                        r_wait_cnt <= 8'd0;
                        r_err      <= 1'b0;
                        r_kill     <= 1'b0;
                        if (w_if_wins) begin
                            r_state     <= c_IF_BUSY;
                            r_grant_mem <= 1'b0;
                            r_fair_cnt  <= 2'd0;
                            r_we        <= 1'b0;
                            r_addr      <= if_addr;
                            r_wdata     <= 32'h0;
                            r_wstrb     <= 4'b0000;
                        end else begin
                            r_state     <= c_MEM_BUSY;
                            r_grant_mem <= 1'b1;
                            // The counter only reaches 2 with if_req high,
                            // in which case IF wins, so it cannot overflow.
                            r_fair_cnt  <= if_req ? r_fair_cnt + 2'd1 : 2'd0;
                            r_we        <= mem_we;
                            r_addr      <= mem_addr;
                            r_wdata     <= mem_wdata;
                            r_wstrb     <= mem_wstrb;
                        end
                    end
                end

                c_IF_BUSY, c_MEM_BUSY: begin
                    r_kill <= w_kill_next;
                    if (bus_ready | w_timeout) begin
                        r_state <= c_RESP;
                        r_err   <= w_timeout;
                        if (r_grant_mem) begin
                            r_mem_rdata <= w_done_data;
                        end else if (!w_kill_next) begin
                            r_if_rdata <= w_done_data;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                default: begin
                    // RESP: a single cycle that never grants.
                    r_state <= c_IDLE;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_valid = (r_state == c_IF_BUSY) | (r_state == c_MEM_BUSY);
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;

    assign if_ready  = w_resp & ~r_grant_mem & ~r_kill;
    assign mem_ready = w_resp & r_grant_mem;
    assign bus_err   = w_resp & r_err;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule
`default_nettype wire
